gtxe2_chnl_rx_align_ctrl: RTL



---
 rtl/gtxe2_chnl_rx_align_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/gtxe2_chnl_rx_align_ctrl.sv
// gtxe2_chnl_rx_align_ctrl
// Word-alignment controller for the GTXE2 RX channel model, usrclk domain.
// Sits between the 8b/10b decoder and gtxe2_chnl_rx_dataiface. It tracks the
// dataiface slot each internal word will occupy. When a lane-0 comma would
// land outside slot 0 it pulses realign, registered together with that word.
// A HUNT/CHECK/LOCKED state machine qualifies alignment.
//
// Ports:
//   usrclk         clock, rising edge
//   reset          synchronous, active-high
//   enable         alignment enable (RXPCOMMAALIGNEN equivalent)
//   indata/inisk   decoded data and per-byte K flags
//   outdata/outisk indata/inisk delayed one cycle (to dataiface)
//   realign        slip request to dataiface, aligned with the comma on outdata
//   byteisaligned  high while LOCKED
//   byterealign    one-cycle pulse when realign is issued from LOCKED
//   commadet       lane-0 comma present on outdata
//   byte_misalign  sticky: comma seen only in a lane other than 0
//   realign_cnt    saturating count of realign pulses
//
// Optional: define GTXE2_CHNL_RX_ALIGN_DBG_EN to print state transitions,
// realign pulses and the first byte_misalign event. The synthesised logic is
// the same with or without it.

module gtxe2_chnl_rx_align_ctrl #(
  parameter int          internal_data_width  = 16,
  parameter int          internal_isk_width   = 2,
  parameter int          interface_data_width = 32,
  parameter logic [7:0]  comma_value          = 8'hBC,
  parameter int          lock_count           = 3,
  parameter int          loss_count           = 4
) (
  input  logic                            usrclk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [internal_data_width-1:0]  indata,
  input  logic [internal_isk_width-1:0]   inisk,
  output logic [internal_data_width-1:0]  outdata,
  output logic [internal_isk_width-1:0]   outisk,
  output logic                            realign,
  output logic                            byteisaligned,
  output logic                            byterealign,
  output logic                            commadet,
  output logic                            byte_misalign,
  output logic [7:0]                      realign_cnt
);

  localparam int         div       = interface_data_width / internal_data_width;
  // The one-cycle pipe puts the word after reset or after a realign in slot 1
  // of the dataiface word counter (slot 0 when div == 1).
  localparam logic [1:0] slot_rst  = 2'(1 % div);
  localparam logic [1:0] slot_last = 2'(div - 1);
  localparam logic [3:0] lock_lim  = 4'(lock_count);
  localparam logic [3:0] loss_lim  = 4'(loss_count);

  typedef enum logic [1:0] {IDLE, HUNT, CHECK, LOCKED} state_t;

  state_t     state;
  logic [1:0] slot;
  logic [3:0] good;
  logic [3:0] bad;

  // Per-lane comma detect
  logic [internal_isk_width-1:0] lane_comma;
  for (genvar b = 0; b < internal_isk_width; b++) begin : g_lane
    assign lane_comma[b] = inisk[b] & (indata[8*b +: 8] == comma_value);
  end

  logic comma0, comma_other, aligned, misaligned;
  assign comma0      = lane_comma[0];
  assign comma_other = |(lane_comma >> 1);
  assign aligned     = comma0 & (slot == 2'd0);
  assign misaligned  = comma0 & (slot != 2'd0);

  logic [3:0] good_inc, bad_inc;
  assign good_inc = good + 4'd1;
  assign bad_inc  = bad + 4'd1;

  // issue: slip request for the current word. loss: LOCKED gives up.
  // A low enable suppresses both, so a drop of enable never slips.
  logic issue, loss;
  always_comb begin
    issue = 1'b0;
    loss  = 1'b0;
    if (enable) begin
      case (state)
        HUNT, CHECK: issue = misaligned;
        LOCKED: begin
          if (misaligned && bad_inc == loss_lim) begin
            issue = 1'b1;
            loss  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge usrclk) begin
    if (reset) begin
      state         <= IDLE;
      slot          <= slot_rst;
      good          <= '0;
      bad           <= '0;
      outdata       <= '0;
      outisk        <= '0;
      realign       <= 1'b0;
      byteisaligned <= 1'b0;
      byterealign   <= 1'b0;
      commadet      <= 1'b0;
      byte_misalign <= 1'b0;
      realign_cnt   <= '0;
    end else begin
      outdata     <= indata;
      outisk      <= inisk;
      realign     <= issue;
      byterealign <= loss;
      commadet    <= comma0;
      if (comma_other && !comma0)
        byte_misalign <= 1'b1;
      if (issue && realign_cnt != 8'hFF)
        realign_cnt <= realign_cnt + 8'd1;
      slot <= issue ? slot_rst : ((slot == slot_last) ? 2'd0 : slot + 2'd1);
      // Registered from the current state: rises one cycle after the locking
      // word is on outdata, but falls together with byterealign.
      byteisaligned <= enable && (state == LOCKED) && !loss;

      if (!enable) begin
        state <= IDLE;
        good  <= '0;
        bad   <= '0;
      end else begin
        case (state)
          IDLE: state <= HUNT;
          HUNT: begin
            if (comma0) begin
              good  <= 4'd1;
              bad   <= '0;
              state <= (lock_count == 1) ? LOCKED : CHECK;
            end
          end
          CHECK: begin
            if (aligned) begin
              good <= good_inc;
              // >= also covers re-entry from LOCKED with lock_count == 1
              if (good_inc >= lock_lim) begin
                state <= LOCKED;
                bad   <= '0;
              end
            end else if (misaligned) begin
              good <= 4'd1;
            end
          end
          LOCKED: begin
            if (aligned) begin
              bad <= '0;
            end else if (misaligned) begin
              if (loss) begin
                state <= CHECK;
                good  <= 4'd1;
              end else begin
                bad <= bad_inc;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef GTXE2_CHNL_RX_ALIGN_DBG_EN
  // Simulation trace. Runs on the same edge as the block, so it reports the
  // previous edge's update (old state held in dbg_state).
  state_t dbg_state;
  logic   dbg_mis;
  always @(posedge usrclk) begin
    if (dbg_state != state)
      $display("%m @%0t: state %s -> %s slot=%0d", $time, dbg_state.name(), state.name(), slot);
    if (realign)
      $display("%m @%0t: realign state %s -> %s slot=%0d cnt=%0d", $time, dbg_state.name(),
               state.name(), slot, realign_cnt);
    if (byte_misalign && !dbg_mis)
      $display("%m @%0t: comma in non-zero lane, state %s slot=%0d", $time, state.name(), slot);
    dbg_state <= state;
    dbg_mis   <= byte_misalign;
  end
`else
  // No simulation trace in the default build.
`endif

endmodule
